// File: rtl/sync_fifo_param_pkg.sv
// Shared types for the parametrised UART-path FIFO.
// Per-cycle operation decoded from flush/push/pop.
package sync_fifo_param_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem_param.sv
// DATA_W x DEPTH register array.
// Synchronous write port, asynchronous read port.
module fifo_mem_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [PTR_W-1:0]  r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with
// occupancy count, threshold flags and sticky errors.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          w_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          r_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             we;
  fifo_op_e         op;

  // Depth need not be a power of two, so wrap by compare.
  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    op = OP_IDLE;
    unique case (1'b1)
      flush:                 op = OP_FLUSH;
      !flush && push && pop: op = OP_BOTH;
      !flush && push && !pop: op = OP_PUSH;
      !flush && !push && pop: op = OP_POP;
      default:               op = OP_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q & ~clr_err;
    udf_d  = udf_q & ~clr_err;
    we     = 1'b0;
    unique case (op)
      OP_FLUSH: begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end
      OP_PUSH: begin
        if (!full_q) begin
          we     = 1'b1;
          wptr_d = ptr_inc(wptr_q);
          cnt_d  = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_q) begin
          rptr_d = ptr_inc(rptr_q);
          cnt_d  = cnt_q - 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
      OP_BOTH: begin
        if (empty_q) begin
          we     = 1'b1;
          wptr_d = ptr_inc(wptr_q);
          cnt_d  = cnt_q + 1'b1;
          udf_d  = 1'b1;
        end else if (full_q) begin
          rptr_d = ptr_inc(rptr_q);
          cnt_d  = cnt_q - 1'b1;
          ovf_d  = 1'b1;
        end else begin
          we     = 1'b1;
          wptr_d = ptr_inc(wptr_q);
          rptr_d = ptr_inc(rptr_q);
        end
      end
      default: ;
    endcase
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
    af_d    = (cnt_d >= CNT_W'(AF_LEVEL));
    ae_d    = (cnt_d <= CNT_W'(AE_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LEVEL == 0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_mem_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk    (clk),
    .we     (we),
    .w_addr (wptr_q),
    .w_data (w_data),
    .r_addr (rptr_q),
    .r_data (r_data)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed vector bench for sync_fifo_param
// at default parameters (8 bits x 8 deep, AF 6, AE 2).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, push, pop, clr_err;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (push),
    .w_data       (w_data),
    .pop          (pop),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       fl, pu, po, ce;
    logic [7:0] wd;
    int         cnt;
    logic       ovf, udf;
    logic       chk;
    logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(
    input string nm, input logic fl, input logic pu,
    input logic po, input logic ce, input logic [7:0] wd,
    input int cnt, input logic ovf, input logic udf,
    input logic chk, input logic [7:0] rd
  );
    vec_t r;
    r.nm = nm; r.fl = fl; r.pu = pu; r.po = po;
    r.ce = ce; r.wd = wd; r.cnt = cnt; r.ovf = ovf;
    r.udf = udf; r.chk = chk; r.rd = rd;
    return r;
  endfunction

  // {count, full, empty, af, ae, ovf, udf}
  function automatic logic [9:0] flags_of(
    input int c, input logic o, input logic u
  );
    return {4'(c), c == 8, c == 0, c >= 6, c <= 2, o, u};
  endfunction

  task automatic check_state(
    input string nm, input int c,
    input logic o, input logic u
  );
    logic [9:0] act, exp;
    act = {count, full, empty, almost_full,
           almost_empty, overflow, underflow};
    exp = flags_of(c, o, u);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s flags got %b want %b", nm, act, exp);
    end
  endtask

  task automatic check_rd(input string nm, input logic [7:0] e);
    checks++;
    if (r_data !== e) begin
      errors++;
      $display("FAIL %s r_data got %h want %h", nm, r_data, e);
    end
  endtask

  task automatic drive(
    input logic fl, input logic pu, input logic po,
    input logic ce, input logic [7:0] wd
  );
    flush = fl; push = pu; pop = po;
    clr_err = ce; w_data = wd;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);

    // table: fill, overflow, drain in order
    vq.push_back(v("idle", 0,0,0,0, 8'h00, 0, 0,0, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      vq.push_back(v("fill", 0,1,0,0, 8'(8'h11 + i),
                     i + 1, 0,0, 1, 8'h11));
    vq.push_back(v("ovf_push", 0,1,0,0, 8'h99, 8, 1,0, 1, 8'h11));
    for (int i = 0; i < 8; i++)
      vq.push_back(v("drain", 0,0,1,0, 8'h00, 7 - i, 1,0,
                     i < 7, 8'(8'h12 + i)));
    vq.push_back(v("clr_ovf", 0,0,0,1, 8'h00, 0, 0,0, 0, 8'h00));
    // underflow and clr_err interplay
    vq.push_back(v("pop_empty", 0,0,1,0, 8'h00, 0, 0,1, 0, 8'h00));
    vq.push_back(v("clr_udf", 0,0,0,1, 8'h00, 0, 0,0, 0, 8'h00));
    vq.push_back(v("clr_set", 0,0,1,1, 8'h00, 0, 0,1, 0, 8'h00));
    vq.push_back(v("clr_udf2", 0,0,0,1, 8'h00, 0, 0,0, 0, 8'h00));
    // wrap: move pointers to 5 then fill through the wrap
    for (int i = 0; i < 5; i++)
      vq.push_back(v("w_push", 0,1,0,0, 8'(8'h21 + i),
                     i + 1, 0,0, 1, 8'h21));
    for (int i = 0; i < 5; i++)
      vq.push_back(v("w_pop", 0,0,1,0, 8'h00, 4 - i, 0,0,
                     i < 4, 8'(8'h22 + i)));
    for (int i = 0; i < 8; i++)
      vq.push_back(v("w_fill", 0,1,0,0, 8'(8'hA0 + i),
                     i + 1, 0,0, 1, 8'hA0));
    for (int i = 0; i < 8; i++)
      vq.push_back(v("w_drain", 0,0,1,0, 8'h00, 7 - i, 0,0,
                     i < 7, 8'(8'hA1 + i)));
    // simultaneous push+pop mid, empty, full
    for (int i = 0; i < 3; i++)
      vq.push_back(v("s_push", 0,1,0,0, 8'(8'h31 + i),
                     i + 1, 0,0, 1, 8'h31));
    vq.push_back(v("both_mid", 0,1,1,0, 8'h34, 3, 0,0, 1, 8'h32));
    vq.push_back(v("s_pop", 0,0,1,0, 8'h00, 2, 0,0, 1, 8'h33));
    vq.push_back(v("s_pop", 0,0,1,0, 8'h00, 1, 0,0, 1, 8'h34));
    vq.push_back(v("s_pop", 0,0,1,0, 8'h00, 0, 0,0, 0, 8'h00));
    vq.push_back(v("both_empty", 0,1,1,0, 8'h41, 1, 0,1, 1, 8'h41));
    vq.push_back(v("clr_b", 0,0,0,1, 8'h00, 1, 0,0, 1, 8'h41));
    for (int i = 0; i < 7; i++)
      vq.push_back(v("f_push", 0,1,0,0, 8'(8'h42 + i),
                     i + 2, 0,0, 1, 8'h41));
    vq.push_back(v("both_full", 0,1,1,0, 8'h49, 7, 1,0, 1, 8'h42));
    vq.push_back(v("clr_c", 0,0,0,1, 8'h00, 7, 0,0, 1, 8'h42));
    vq.push_back(v("to5", 0,0,1,0, 8'h00, 6, 0,0, 1, 8'h43));
    vq.push_back(v("to5", 0,0,1,0, 8'h00, 5, 0,0, 1, 8'h44));
    // flush beats push and pop, sets no error
    vq.push_back(v("flush5", 1,1,0,0, 8'h77, 0, 0,0, 0, 8'h00));
    vq.push_back(v("flush_pop", 1,0,1,0, 8'h00, 0, 0,0, 0, 8'h00));
    vq.push_back(v("post_fl", 0,1,0,0, 8'h55, 1, 0,0, 1, 8'h55));
    for (int i = 1; i < 8; i++)
      vq.push_back(v("pf_push", 0,1,0,0, 8'(8'h55 + i),
                     i + 1, 0,0, 1, 8'h55));
    vq.push_back(v("flush_full", 1,1,0,0, 8'hEE, 0, 0,0, 0, 8'h00));

    // reset state, checked while reset is held
    #12;
    check_state("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].fl, vq[k].pu, vq[k].po, vq[k].ce, vq[k].wd);
      @(posedge clk);
      #1;
      check_state(vq[k].nm, vq[k].cnt, vq[k].ovf, vq[k].udf);
      if (vq[k].chk) check_rd(vq[k].nm, vq[k].rd);
    end

    // async reset in the middle of a push burst
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 8'(8'h61 + i));
    end
    @(posedge clk);
    #2;
    check_state("burst3", 3, 0, 0);
    check_rd("burst3", 8'h61);
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    check_state("rst_held", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 8'h70);
    @(posedge clk);
    #1;
    check_state("post_rst", 1, 0, 0);
    check_rd("post_rst", 8'h70);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the 9-bit/4-deep UART-path FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between a UART RX/TX datapath and its consumer/producer.
- Read data is show-ahead: the head entry is visible combinationally whenever not empty.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all state; has priority over push and pop.
- push  in  1  write request.
- w_data  in  DATA_W  write data.
- pop  in  1  read request; consumes the head entry.
- r_data  out  DATA_W  head entry, combinational from storage at rptr.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  CNT_W  occupancy, where CNT_W = $clog2(DEPTH+1).
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was dropped.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr = rptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0).
  - overflow = underflow = 0.
  - r_data is undefined; storage is not reset.
- All flags are registered. They are either derived from registered count or registered directly; full and empty must be glitch-free register outputs. Flags update in the same edge as the pointer/count change.
- Pointers are binary 0..DEPTH-1. Increment wraps from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Write latency: an accepted push writes w_data at the clock edge. It is visible on r_data the next cycle if the FIFO was empty. There is no fall-through in the same cycle.
- Per-cycle decision (evaluated on registered state):
  - flush: wptr = rptr = count = 0, empty = 1. push/pop ignored, no error flags set. Storage is untouched.
  - push only:
    - not full: write, wptr++, count++.
    - full: drop the push, set overflow.
  - pop only:
    - not empty: rptr++, count--.
    - empty: drop the pop, set underflow.
  - push and pop:
    - empty: push accepted, pop dropped, underflow set, count = 1.
    - full: pop accepted, push dropped, overflow set, count = DEPTH-1.
    - otherwise: both accepted, both pointers advance, count unchanged.
- Error flags:
  - clr_err clears overflow/underflow.
  - If a new error event occurs in the same cycle as clr_err, the flag is set (set wins).
- Storage write enable = push & ~full & ~flush.
- Reset asserted mid-operation aborts immediately. Contents are lost logically (empty = 1).

Decomposition:
- No shared package needed.
- CNT_W and PTR_W = $clog2(DEPTH) are localparams.
- Natural sub-module: fifo_mem_param. It is a DATA_W x DEPTH register array with a synchronous write port (we, w_addr, w_data) and an asynchronous read port (r_addr -> r_data).
- Control logic stays in the top level as reg/next pairs with a single combinational next-state block.

Test Plan:
- Reset then idle: count = 0, empty = 1, almost_empty = 1, full = 0, overflow = underflow = 0.
- Push 0x11..0x18 (8 words, defaults): full = 1 after the 8th edge; almost_full asserts after the 6th push. A 9th push sets overflow and leaves count = 8. Pop 8 times: r_data reads 0x11..0x18 in order, empty after the last pop.
- Pop when empty: underflow = 1, count stays 0. clr_err clears it next cycle. clr_err together with another pop-on-empty keeps underflow = 1.
- Wrap test: push 5, pop 5, then push 0xA0..0xA7. Pointers wrap, data order is preserved, full = 1 at count 8.
- Simultaneous push+pop:
  - at count 3: count stays 3, r_data advances.
  - at empty: count becomes 1, underflow = 1.
  - at full: count becomes 7, overflow = 1.
- Flush at count 5 with push = 1: next cycle count = 0, empty = 1, no overflow. Also: rst_n pulsed low mid-burst asynchronously forces empty = 1 before the next clock edge.
